// File: rtl/decode_pkg.sv
// ============================================================================
// Package     : decode_pkg
// Description : Shared LC-3 decode types and the decode_instr() function,
//               used by the decode stage and by the decode_out predictor.
//               Contents: opcode enum, write-back select enum, e_control
//               field struct, per-instruction control bundle struct.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RSV  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    // Write-back source selected in the writeback stage.
    typedef enum logic [1:0] {
        W_ALU = 2'b00,
        W_PC  = 2'b01,
        W_MEM = 2'b10
    } wsel_e;

    // Packs to {alu_ctl[1:0], pcsel1[1:0], pcsel2, op2sel}.
    typedef struct packed {
        logic [1:0] alu_ctl;
        logic [1:0] pcsel1;
        logic       pcsel2;
        logic       op2sel;
    } e_control_t;

    typedef struct packed {
        e_control_t e_control;
        logic       mem_control;
        wsel_e      w_control;
        logic       illegal;
    } decode_bundle_t;

    // Control decode of one instruction. Only the opcode and IR[5]
    // (immediate-vs-register select) influence the control fields.
    function automatic decode_bundle_t decode_instr(input logic [3:0] opcode,
                                                   input logic       imm_bit);
        decode_bundle_t b;
        b = '0;
        case (opcode_e'(opcode))
            OP_ADD: begin
                b.e_control.op2sel = imm_bit;
            end
            OP_AND: begin
                b.e_control.alu_ctl = 2'b01;
                b.e_control.op2sel  = imm_bit;
            end
            OP_NOT: begin
                b.e_control.alu_ctl = 2'b10;
            end
            OP_BR: begin
                b.e_control.pcsel1 = 2'b01;
                b.e_control.pcsel2 = 1'b1;
            end
            OP_JMP: begin
                b.e_control.pcsel1 = 2'b11;
            end
            OP_LD: begin
                b.e_control.pcsel1 = 2'b01;
                b.e_control.pcsel2 = 1'b1;
                b.w_control        = W_MEM;
            end
            OP_LDI: begin
                b.e_control.pcsel1 = 2'b01;
                b.e_control.pcsel2 = 1'b1;
                b.w_control        = W_MEM;
                b.mem_control      = 1'b1;
            end
            OP_LDR: begin
                b.e_control.pcsel1 = 2'b10;
                b.w_control        = W_MEM;
            end
            OP_LEA: begin
                b.e_control.pcsel1 = 2'b01;
                b.e_control.pcsel2 = 1'b1;
                b.w_control        = W_PC;
            end
            OP_ST: begin
                b.e_control.pcsel1 = 2'b01;
                b.e_control.pcsel2 = 1'b1;
            end
            OP_STI: begin
                b.e_control.pcsel1 = 2'b01;
                b.e_control.pcsel2 = 1'b1;
                b.mem_control      = 1'b1;
            end
            OP_STR: begin
                b.e_control.pcsel1 = 2'b10;
            end
            default: begin
                b.illegal = 1'b1;
            end
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_bundle_fifo.sv
// ============================================================================
// Module      : decode_bundle_fifo
// Description : DEPTH-entry FIFO holding decoded bundles between decode and
//               execute. Pointers wrap modulo DEPTH so any DEPTH >= 1 works.
//               Synchronous flush empties the queue and overrides push/pop.
// Ports       : clk_i, rst_ni   clock / async active-low reset
//               push_i, pop_i   write / read strobes (already qualified)
//               flush_i         discard all entries
//               data_i          bundle to write
//               head_o, valid_o oldest bundle and its valid flag
//               count_o         occupancy
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_bundle_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  T                 data_i,
    output T                 head_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Explicit wrap so non-power-of-two depths never index past the array.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (push_i && !pop_i) begin
                count_d = count_q + 1'b1;
            end else if (pop_i && !push_i) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read while count is zero.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/decode_stage_q.sv
// ============================================================================
// Module      : decode_stage_q
// Description : LC-3 decode stage with an output queue. Each accepted fetch
//               word is decoded and pushed with its npc; execute drains the
//               queue with valid/ready so decode keeps running through
//               execute stalls.
// Ports       : clock_i, reset_ni      clock / async active-low reset
//               enable_decode_i        gates pushes (pops still allowed)
//               flush_i                discard queued bundles
//               in_valid_i/in_ready_o  fetch handshake
//               instr_dout_i, npc_in_i fetched instruction and its PC+1
//               out_valid_o/out_ready_i execute handshake
//               ir_o, e_control_o, npc_out_o, mem_control_o, w_control_o,
//               illegal_o              head bundle (all zero when empty)
//               count_o                queue occupancy
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage_q
    import decode_pkg::*;
#(
    parameter int  IR_W  = 16,
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             enable_decode_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IR_W-1:0]  instr_dout_i,
    input  logic [IR_W-1:0]  npc_in_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [IR_W-1:0]  ir_o,
    output logic [5:0]       e_control_o,
    output logic [IR_W-1:0]  npc_out_o,
    output logic             mem_control_o,
    output logic [1:0]       w_control_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] count_o
);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [IR_W-1:0] npc;
        decode_bundle_t  ctrl;
    } entry_t;

    entry_t           entry_d;
    entry_t           head;
    logic             head_valid;
    logic [CNT_W-1:0] count;
    logic             alive_q;
    logic             push;
    logic             pop;

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    always_comb begin
        entry_d      = '0;
        entry_d.ir   = instr_dout_i;
        entry_d.npc  = npc_in_i;
        entry_d.ctrl = decode_instr(instr_dout_i[IR_W-1 -: 4], instr_dout_i[5]);
    end

    // A full queue still accepts when execute drains the head this cycle.
    assign in_ready_o = alive_q && enable_decode_i
                        && ((count < CNT_W'(DEPTH)) || out_ready_i);
    assign push       = in_valid_i && in_ready_o;
    assign pop        = head_valid && out_ready_i;

    decode_bundle_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk_i   (clock_i),
        .rst_ni  (reset_ni),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_i),
        .data_i  (entry_d),
        .head_o  (head),
        .valid_o (head_valid),
        .count_o (count)
    );

    // Stale storage is masked so an empty queue presents an all-zero bundle.
    assign out_valid_o   = head_valid;
    assign ir_o          = head_valid ? head.ir                 : '0;
    assign npc_out_o     = head_valid ? head.npc                : '0;
    assign e_control_o   = head_valid ? head.ctrl.e_control     : '0;
    assign mem_control_o = head_valid ? head.ctrl.mem_control   : 1'b0;
    assign w_control_o   = head_valid ? head.ctrl.w_control     : 2'b00;
    assign illegal_o     = head_valid ? head.ctrl.illegal       : 1'b0;
    assign count_o       = count;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_q.sv
// ============================================================================
// Module      : tb_decode_stage_q
// Description : Self-checking bench for decode_stage_q (IR_W=16, DEPTH=2)
//               with a queue-based reference model and a table-driven
//               decode reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage_q;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] npc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ir;
    logic [5:0]  ectl;
    logic [15:0] npc_out;
    logic        mem;
    logic [1:0]  w;
    logic        ill;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mq_ir[$];
    logic [15:0] mq_npc[$];
    bit          alive = 1'b0;

    always #5 clk = ~clk;

    decode_stage_q #(.IR_W(16), .DEPTH(DEPTH)) dut (
        .clock_i         (clk),
        .reset_ni        (rst_n),
        .enable_decode_i (en),
        .flush_i         (flush),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .instr_dout_i    (instr),
        .npc_in_i        (npc),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .ir_o            (ir),
        .e_control_o     (ectl),
        .npc_out_o       (npc_out),
        .mem_control_o   (mem),
        .w_control_o     (w),
        .illegal_o       (ill),
        .count_o         (count)
    );

    // Instruction table: returns {e_control[5:0], mem, w[1:0], illegal}.
    function automatic logic [9:0] ref_decode(input logic [15:0] i);
        logic [5:0] e;
        logic       m;
        logic [1:0] wb;
        logic       il;
        e = 6'b0; m = 1'b0; wb = 2'b00; il = 1'b0;
        case (i[15:12])
            4'h1: e  = {5'b00000, i[5]};
            4'h5: e  = {5'b01000, i[5]};
            4'h9: e  = 6'b100000;
            4'h0: e  = 6'b000110;
            4'hC: e  = 6'b001100;
            4'h2: begin e = 6'b000110; wb = 2'b10; end
            4'hA: begin e = 6'b000110; wb = 2'b10; m = 1'b1; end
            4'h6: begin e = 6'b001000; wb = 2'b10; end
            4'hE: begin e = 6'b000110; wb = 2'b01; end
            4'h3: e  = 6'b000110;
            4'hB: begin e = 6'b000110; m = 1'b1; end
            4'h7: e  = 6'b001000;
            default: il = 1'b1;
        endcase
        return {e, m, wb, il};
    endfunction

    function automatic bit mdl_in_ready();
        return alive && en && ((mq_ir.size() < DEPTH) || out_ready);
    endfunction

    // Advance one clock edge, applying the same inputs to the model.
    task automatic tick();
        bit m_push;
        bit m_pop;
        @(posedge clk);
        m_push = in_valid && mdl_in_ready();
        m_pop  = (mq_ir.size() > 0) && out_ready;
        if (rst_n) begin
            if (flush) begin
                mq_ir.delete();
                mq_npc.delete();
            end else begin
                if (m_pop) begin
                    void'(mq_ir.pop_front());
                    void'(mq_npc.pop_front());
                end
                if (m_push) begin
                    mq_ir.push_back(instr);
                    mq_npc.push_back(npc);
                end
            end
            alive = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
        instr = '0; npc = '0; out_ready = 1'b0;
        #3;
        checks++;
        if ({out_valid, count, in_ready, ir, ectl} !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b count=%0d rdy=%b ir=%h ectl=%b, want all 0",
                     out_valid, count, in_ready, ir, ectl);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1; en = 1'b1; in_valid = 1'b1; instr = 16'h1261;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_first_edge: got %b want 0", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_push_after_reset: got count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_add();
        in_valid = 1'b1; instr = 16'h1261; npc = 16'h3001; out_ready = 1'b1; en = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_in_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (ir !== 16'h1261 || ectl !== 6'b000001 || w !== 2'b00 || npc_out !== 16'h3001
            || out_valid !== 1'b1 || ill !== 1'b0) begin
            errors++;
            $display("FAIL add_head: got ir=%h ectl=%b w=%b npc=%h v=%b ill=%b want 1261/000001/00/3001/1/0",
                     ir, ectl, w, npc_out, out_valid, ill);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || ir !== 16'h0 || npc_out !== 16'h0 || count !== 2'd0) begin
            errors++;
            $display("FAIL empty_outputs_zero: got v=%b ir=%h npc=%h count=%0d want 0", out_valid, ir, npc_out, count);
        end
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 16'h2A05; npc = 16'h0101; tick();
        instr = 16'hA403; npc = 16'h0102; tick();
        instr = 16'h5020; npc = 16'h0103;
        #1;
        checks++;
        if (count !== 2'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_backpressure: got count=%0d rdy=%b want 2/0", count, in_ready);
        end
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (count !== 2'd2 || ir !== 16'h2A05 || w !== 2'b10 || mem !== 1'b0 || ectl !== 6'b000110) begin
            errors++;
            $display("FAIL drain_ld: got count=%0d ir=%h w=%b mem=%b ectl=%b want 2/2a05/10/0/000110",
                     count, ir, w, mem, ectl);
        end
        tick();
        checks++;
        if (ir !== 16'hA403 || w !== 2'b10 || mem !== 1'b1 || npc_out !== 16'h0102) begin
            errors++;
            $display("FAIL drain_ldi: got ir=%h w=%b mem=%b npc=%h want a403/10/1/0102", ir, w, mem, npc_out);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL refused_push_absent: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            instr = 16'($urandom); npc = 16'($urandom); tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            instr = 16'($urandom); npc = 16'($urandom);
            #1;
            checks++;
            if (in_ready !== 1'b1 || ir !== mq_ir[0] || npc_out !== mq_npc[0]) begin
                errors++;
                $display("FAIL wrap_order[%0d]: got rdy=%b ir=%h npc=%h want 1/%h/%h",
                         k, in_ready, ir, npc_out, mq_ir[0], mq_npc[0]);
            end
            tick();
            checks++;
            if (count !== 2'd2) begin
                errors++;
                $display("FAIL wrap_count[%0d]: got %0d want 2", k, count);
            end
        end
    endtask

    task automatic test_flush();
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; instr = 16'h1111;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_in_ready: got %b want 1", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: got count=%0d valid=%b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 16'hD000; npc = 16'h0200; tick();
        instr = 16'hF025; npc = 16'h0201; tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (ir !== 16'hD000 || ill !== 1'b1 || ectl !== 6'b0 || w !== 2'b00 || mem !== 1'b0) begin
            errors++;
            $display("FAIL illegal_rsv: got ir=%h ill=%b ectl=%b w=%b mem=%b want d000/1/0/00/0",
                     ir, ill, ectl, w, mem);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (ir !== 16'hF025 || ill !== 1'b1 || ectl !== 6'b0) begin
            errors++;
            $display("FAIL illegal_trap: got ir=%h ill=%b ectl=%b want f025/1/0", ir, ill, ectl);
        end
        tick();
        en = 1'b0; in_valid = 1'b1; out_ready = 1'b0; instr = 16'h1234;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL disabled_ready: got %b want 0", in_ready);
        end
        tick();
        checks++;
        if (count !== 2'd0) begin
            errors++;
            $display("FAIL disabled_no_push: got count=%0d want 0", count);
        end
        en = 1'b1; in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [9:0]  d;
        logic [47:0] got;
        logic [47:0] exp;
        for (int k = 0; k < 400; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            en        = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            instr     = 16'($urandom);
            npc       = 16'($urandom);
            #1;
            if (mq_ir.size() > 0) begin
                d   = ref_decode(mq_ir[0]);
                exp = {1'b1, 2'(mq_ir.size()), mdl_in_ready(), mq_ir[0], mq_npc[0], d};
            end else begin
                exp = {1'b0, 2'd0, mdl_in_ready(), 16'h0, 16'h0, 10'h0};
            end
            got = {out_valid, count, in_ready, ir, npc_out, ectl, mem, w, ill};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h (v,cnt,rdy,ir,npc,ectl,mem,w,ill)", k, got, exp);
            end
            tick();
        end
        flush = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; instr = 16'h1045; npc = 16'h0300;
        tick();
        instr = 16'hE123;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, count, in_ready, ir, npc_out, ectl, w, ill} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b count=%0d rdy=%b ir=%h npc=%h, want all 0",
                     out_valid, count, in_ready, ir, npc_out);
        end
        mq_ir.delete(); mq_npc.delete(); alive = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_mid: got rdy=%b valid=%b want 1/0", in_ready, out_valid);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_fill_drain();
        test_wrap();
        test_flush();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
